// File: rtl/activation_loader_pkg.sv
// Shared widths, FSM encoding and channel unpack helpers for the activation loader.
package activation_loader_pkg;
  localparam int DAT_WIDTH     = 8;
  localparam int NUM_CHANNEL   = 3;
  localparam int FF_DEPTH      = 8;
  localparam int FF_ADDR_WIDTH = 3;
  localparam int ADDR_WIDTH    = 12;
  localparam int POS_WIDTH     = 12;
  localparam int MEM_LATENCY   = 1;
  localparam int CNT_WIDTH     = FF_ADDR_WIDTH + 1;
  localparam int OUT_WIDTH     = $clog2(MEM_LATENCY + 2);
  localparam int WORD_WIDTH    = DAT_WIDTH * NUM_CHANNEL;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  function automatic logic [DAT_WIDTH-1:0] ch_slice(input logic [WORD_WIDTH-1:0] w, input int ch);
    return w[ch*DAT_WIDTH +: DAT_WIDTH];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] max3(input logic [CNT_WIDTH-1:0] a, b, c);
    logic [CNT_WIDTH-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/activation_loader_if.sv
// Loader-side bus: control, activation memory read port and input_buffer write side.
interface activation_loader_if;
  import activation_loader_pkg::*;
  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_base_addr;
  logic [POS_WIDTH-1:0]  i_num_pos;
  logic                  o_mem_rd_en;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [WORD_WIDTH-1:0] i_mem_rd_data;
  logic [DAT_WIDTH-1:0]  o_data_ch0, o_data_ch1, o_data_ch2;
  logic                  o_data_ch0_val, o_data_ch1_val, o_data_ch2_val;
  logic [CNT_WIDTH-1:0]  i_data_counter_ch0, i_data_counter_ch1, i_data_counter_ch2;
  logic                  i_full;
  logic                  o_busy, o_done, o_overflow;

  modport master (
    input  i_start, i_base_addr, i_num_pos, i_mem_rd_data,
           i_data_counter_ch0, i_data_counter_ch1, i_data_counter_ch2, i_full,
    output o_mem_rd_en, o_mem_addr, o_data_ch0, o_data_ch1, o_data_ch2,
           o_data_ch0_val, o_data_ch1_val, o_data_ch2_val, o_busy, o_done, o_overflow
  );

  modport slave (
    output i_start, i_base_addr, i_num_pos, i_mem_rd_data,
           i_data_counter_ch0, i_data_counter_ch1, i_data_counter_ch2, i_full,
    input  o_mem_rd_en, o_mem_addr, o_data_ch0, o_data_ch1, o_data_ch2,
           o_data_ch0_val, o_data_ch1_val, o_data_ch2_val, o_busy, o_done, o_overflow
  );
endinterface

// File: rtl/activation_loader_rd_inflight_tracker.sv
// Shift register of issued reads: popcount gives reads still invisible in the FIFO counters,
// tap MEM_LATENCY-1 marks the cycle the read data arrives.
module rd_inflight_tracker
  import activation_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rd_en,
  output logic [OUT_WIDTH-1:0] o_outstanding,
  output logic                 o_wr_val
);
  logic [MEM_LATENCY:0] vld_pipe_q, vld_pipe_d;
  logic [OUT_WIDTH-1:0] cnt;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[MEM_LATENCY-1:0], i_rd_en};
    cnt = '0;
    for (int i = 0; i <= MEM_LATENCY; i++) cnt = cnt + OUT_WIDTH'(vld_pipe_q[i]);
  end

  assign o_outstanding = cnt;
  assign o_wr_val      = vld_pipe_q[MEM_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= vld_pipe_d;
  end
endmodule

// File: rtl/activation_loader.sv
// Streams activation positions from memory into the three input_buffer FIFOs with
// credit-based issue so no FIFO ever overflows.
module activation_loader
  import activation_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  activation_loader_if.master  bus
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [POS_WIDTH-1:0]  num_pos_q, num_pos_d;
  logic [POS_WIDTH-1:0]  idx_q, idx_d;
  logic [POS_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic                  overflow_q, overflow_d;

  logic                  issue, wr_val, credit_ok;
  logic [OUT_WIDTH-1:0]  outstanding;
  logic [CNT_WIDTH-1:0]  max_cnt;

  rd_inflight_tracker u_trk (
    .clk           (clk),
    .rst           (rst),
    .i_rd_en       (issue),
    .o_outstanding (outstanding),
    .o_wr_val      (wr_val)
  );

  // Counters lag one cycle, so reads of the last MEM_LATENCY+1 cycles count as occupied slots.
  assign max_cnt   = max3(bus.i_data_counter_ch0, bus.i_data_counter_ch1, bus.i_data_counter_ch2);
  assign credit_ok = (16'(max_cnt) + 16'(outstanding)) <= 16'(FF_DEPTH - 1);
  assign issue     = (state_q == ST_RUN) && credit_ok && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_pos_q  <= '0;
      idx_q      <= '0;
      wr_cnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_pos_q  <= num_pos_d;
      idx_q      <= idx_d;
      wr_cnt_q   <= wr_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_pos_d  = num_pos_q;
    idx_d      = idx_q;
    wr_cnt_d   = wr_val ? wr_cnt_q + POS_WIDTH'(1) : wr_cnt_q;
    overflow_d = overflow_q | (wr_val & bus.i_full);
    case (state_q)
      ST_IDLE: if (bus.i_start) begin
        base_d    = bus.i_base_addr;
        num_pos_d = bus.i_num_pos;
        idx_d     = '0;
        wr_cnt_d  = '0;
        state_d   = (bus.i_num_pos != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: if (issue) begin
        idx_d = idx_q + POS_WIDTH'(1);
        if (idx_q == num_pos_q - POS_WIDTH'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (wr_val && wr_cnt_q == num_pos_q - POS_WIDTH'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_mem_rd_en    = issue;
    bus.o_mem_addr     = issue ? base_q + ADDR_WIDTH'(idx_q) : '0;
    bus.o_data_ch0_val = wr_val && !rst;
    bus.o_data_ch1_val = wr_val && !rst;
    bus.o_data_ch2_val = wr_val && !rst;
    bus.o_data_ch0     = (wr_val && !rst) ? ch_slice(bus.i_mem_rd_data, 0) : '0;
    bus.o_data_ch1     = (wr_val && !rst) ? ch_slice(bus.i_mem_rd_data, 1) : '0;
    bus.o_data_ch2     = (wr_val && !rst) ? ch_slice(bus.i_mem_rd_data, 2) : '0;
    bus.o_busy         = (state_q != ST_IDLE) && !rst;
    bus.o_done         = (state_q == ST_DONE) && !rst;
    bus.o_overflow     = overflow_q;
  end
endmodule

// File: tb/tb_activation_loader.sv
// Directed bench: memory + FIFO occupancy model around activation_loader, table of transfers
// plus backpressure, busy-start and mid-transfer reset sequences.
module tb_activation_loader;
  import activation_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  activation_loader_if bus ();
  activation_loader dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WORD_WIDTH-1:0] mem_word(input logic [ADDR_WIDTH-1:0] a);
    logic [7:0] b0, b1, b2;
    b0 = a[7:0];
    b1 = a[11:4] ^ 8'h3C;
    b2 = ~a[7:0];
    return {b2, b1, b0};
  endfunction

  // memory with one cycle read latency
  logic [WORD_WIDTH-1:0] mem_q = '0;
  always @(posedge clk) if (bus.o_mem_rd_en) mem_q <= mem_word(bus.o_mem_addr);
  assign bus.i_mem_rd_data = mem_q;

  // input_buffer occupancy model (all three FIFOs move together)
  logic       pop_en = 1'b0;
  logic [3:0] occ_q = '0;
  logic       pop;
  assign pop = pop_en && (occ_q != 0);
  always @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_q + 4'(bus.o_data_ch0_val) - 4'(pop);
  end
  assign bus.i_data_counter_ch0 = occ_q;
  assign bus.i_data_counter_ch1 = occ_q;
  assign bus.i_data_counter_ch2 = occ_q;
  assign bus.i_full             = (occ_q == 4'd8);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // event logs
  logic [ADDR_WIDTH-1:0] rd_addrs[$];
  int n_val = 0, n_done = 0, first_rd = -1, first_val = -1, done_cyc = -1;

  task automatic clr_logs();
    rd_addrs.delete();
    n_val = 0; n_done = 0; first_rd = -1; first_val = -1; done_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (bus.o_mem_rd_en) begin
      rd_addrs.push_back(bus.o_mem_addr);
      if (first_rd < 0) first_rd = cyc;
    end
    if (bus.o_data_ch0_val || bus.o_data_ch1_val || bus.o_data_ch2_val) begin
      logic [WORD_WIDTH-1:0] w;
      check("val_together", {29'd0, bus.o_data_ch0_val, bus.o_data_ch1_val, bus.o_data_ch2_val}, 32'h7);
      if (n_val < rd_addrs.size()) begin
        w = mem_word(rd_addrs[n_val]);
        check("data_ch0", 32'(bus.o_data_ch0), 32'(w[7:0]));
        check("data_ch1", 32'(bus.o_data_ch1), 32'(w[15:8]));
        check("data_ch2", 32'(bus.o_data_ch2), 32'(w[23:16]));
      end else check("val_without_read", 32'(n_val), 32'(rd_addrs.size()));
      if (first_val < 0) first_val = cyc;
      n_val++;
    end
    if (bus.o_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // returns cycle in which start was high
  task automatic pulse_start(input logic [11:0] base, input logic [11:0] num, output int t0);
    bus.i_start = 1'b1; bus.i_base_addr = base; bus.i_num_pos = num;
    t0 = cyc;
    tick(1);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(n_done > 0), 32'd1);
  endtask

  typedef struct {
    logic [11:0] base;
    logic [11:0] num;
    logic [11:0] first_addr;
    logic [11:0] last_addr;
    int          done_ofs;
  } vec_t;

  vec_t vecs[5];
  int t0, t1;

  initial begin
    vecs[0] = '{12'h010, 12'd5,  12'h010, 12'h014, 7};
    vecs[1] = '{12'hFFE, 12'd4,  12'hFFE, 12'h001, 6};
    vecs[2] = '{12'h000, 12'd0,  12'h000, 12'h000, 1};
    vecs[3] = '{12'h7F0, 12'd1,  12'h7F0, 12'h7F0, 3};
    vecs[4] = '{12'h100, 12'd12, 12'h100, 12'h10B, 14};

    bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_num_pos = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          32'({bus.o_mem_rd_en, bus.o_mem_addr, bus.o_data_ch0_val, bus.o_data_ch1_val, bus.o_data_ch2_val,
               bus.o_busy, bus.o_done, bus.o_overflow}), 32'd0);
    check("reset_data", 32'({bus.o_data_ch0, bus.o_data_ch1, bus.o_data_ch2}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);
    check("idle_busy", 32'(bus.o_busy), 32'd0);

    // table of transfers with a continuously draining consumer
    pop_en = 1'b1;
    foreach (vecs[i]) begin
      clr_logs();
      pulse_start(vecs[i].base, vecs[i].num, t0);
      wait_done($sformatf("v%0d_done_seen", i), 100);
      tick(3);
      check($sformatf("v%0d_n_rd", i), 32'(rd_addrs.size()), 32'(vecs[i].num));
      check($sformatf("v%0d_n_val", i), 32'(n_val), 32'(vecs[i].num));
      check($sformatf("v%0d_done_ofs", i), 32'(done_cyc - t0), 32'(vecs[i].done_ofs));
      check($sformatf("v%0d_n_done", i), 32'(n_done), 32'd1);
      if (vecs[i].num != 0 && rd_addrs.size() > 0) begin
        check($sformatf("v%0d_first_addr", i), 32'(rd_addrs[0]), 32'(vecs[i].first_addr));
        check($sformatf("v%0d_last_addr", i), 32'(rd_addrs[$]), 32'(vecs[i].last_addr));
        check($sformatf("v%0d_rd_lat", i), 32'(first_rd - t0), 32'd1);
        check($sformatf("v%0d_val_lat", i), 32'(first_val - t0), 32'd2);
        for (int k = 1; k < rd_addrs.size(); k++)
          check($sformatf("v%0d_addr%0d", i, k), 32'(rd_addrs[k]), 32'(12'(rd_addrs[k-1] + 12'd1)));
      end
    end

    // backpressure: no consumer, FIFOs must fill to exactly 8
    clr_logs();
    pop_en = 1'b0;
    pulse_start(12'h200, 12'd20, t0);
    tick(30);
    check("bp_fill_vals", 32'(n_val), 32'd8);
    check("bp_fill_rds", 32'(rd_addrs.size()), 32'd8);
    check("bp_occ", 32'(occ_q), 32'd8);
    check("bp_busy", 32'(bus.o_busy), 32'd1);
    check("bp_overflow", 32'(bus.o_overflow), 32'd0);
    pop_en = 1'b1;
    tick(3);
    pop_en = 1'b0;
    tick(20);
    check("bp_three_more", 32'(n_val), 32'd11);
    check("bp_occ_refill", 32'(occ_q), 32'd8);
    pop_en = 1'b1;
    wait_done("bp_done_seen", 200);
    tick(4);
    check("bp_all_vals", 32'(n_val), 32'd20);
    check("bp_last_addr", 32'(rd_addrs[$]), 32'h213);
    check("bp_n_done", 32'(n_done), 32'd1);
    check("bp_overflow_end", 32'(bus.o_overflow), 32'd0);
    check("bp_idle", 32'(bus.o_busy), 32'd0);

    // start while busy must be ignored
    clr_logs();
    pulse_start(12'h300, 12'd6, t0);
    tick(1);
    pulse_start(12'h500, 12'd3, t1);
    wait_done("busy_done_seen", 100);
    tick(4);
    check("busy_n_rd", 32'(rd_addrs.size()), 32'd6);
    check("busy_first", 32'(rd_addrs[0]), 32'h300);
    check("busy_last", 32'(rd_addrs[$]), 32'h305);
    check("busy_n_done", 32'(n_done), 32'd1);
    check("busy_done_ofs", 32'(done_cyc - t0), 32'd8);

    // reset in the middle of a transfer with a read in flight
    clr_logs();
    pulse_start(12'h400, 12'd10, t0);
    tick(2);
    check("mid_busy", 32'(bus.o_busy), 32'd1);
    check("mid_inflight", 32'(bus.o_mem_rd_en), 32'd1);
    rst = 1'b1;
    clr_logs();
    tick(1);
    rst = 1'b0;
    tick(6);
    check("mid_no_val", 32'(n_val), 32'd0);
    check("mid_no_rd", 32'(rd_addrs.size()), 32'd0);
    check("mid_idle", 32'(bus.o_busy), 32'd0);
    check("mid_no_done", 32'(n_done), 32'd0);
    pulse_start(12'h020, 12'd3, t0);
    wait_done("mid_restart_done", 100);
    tick(2);
    check("mid_restart_vals", 32'(n_val), 32'd3);
    check("mid_restart_first", 32'(rd_addrs.size() > 0 ? rd_addrs[0] : 12'hFFF), 32'h020);
    check("mid_restart_ofs", 32'(done_cyc - t0), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
